// File: rtl/vehicle_sensor_conditioner.sv
// Turns the raw loop-detector level into the debounced, grant-aware sensor request for traffic_controller.
// Optional saturating vehicle counter (port vehicle_count) is built only when VEHICLE_COUNT_EN is defined.
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 3
`ifdef VEHICLE_COUNT_EN
  ,
  parameter int CNT_W           = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_det,
  input  logic [1:0]       country,
  output logic             sensor
`ifdef VEHICLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] vehicle_count
`endif
);

  localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int GAP_BITS = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, QUALIFY, REQUEST, SERVED, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic                sync1_q, det_s_q;
  logic                sensor_q, sensor_d;
  logic                green;

  assign green = (country == 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      det_s_q <= 1'b0;
    end else begin
      sync1_q <= raw_det;
      det_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      sensor_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sensor_q <= sensor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (det_s_q) begin
          state_d = QUALIFY;
          cnt_d   = CNT_BITS'(1);
        end
      end
      QUALIFY: begin
        if (!det_s_q)
          state_d = IDLE;
        else if (cnt_q == CNT_BITS'(DEBOUNCE_CYCLES - 1))
          state_d = REQUEST;
        else
          cnt_d = cnt_q + 1'b1;
      end
      REQUEST: begin
        if (green) begin
          state_d = SERVED;
          gap_d   = '0;
        end
      end
      SERVED: begin
        // Losing green ends service even while a gap is still being timed.
        if (!green)
          state_d = IDLE;
        else if (det_s_q)
          gap_d = '0;
        else begin
          gap_d = gap_q + 1'b1;
          if (gap_q == GAP_BITS'(GAP_CYCLES - 1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!green)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sensor_d = (state_d == REQUEST) || (state_d == SERVED);
  end

  assign sensor = sensor_q;

`ifdef VEHICLE_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else if (state_q == QUALIFY && state_d == REQUEST && count_q != '1)
      count_q <= count_q + 1'b1;
  end

  assign vehicle_count = count_q;
`endif

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed and randomized bench for vehicle_sensor_conditioner against a run-length based reference model.
module tb_vehicle_sensor_conditioner;

  localparam int DEB = 4;
  localparam int GAP = 3;
`ifdef VEHICLE_COUNT_EN
  localparam int CW = 2;
  logic [CW-1:0] vehicle_count;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       raw_det = 1'b0;
  logic [1:0] country = 2'd0;
  logic       sensor;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: detector pipeline plus request lifecycle flags and run lengths.
  bit m_s1, m_s2;
  bit m_pending, m_granted, m_drained;
  int m_high, m_low, m_count;

  always #5 clk = ~clk;

  vehicle_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAP)
`ifdef VEHICLE_COUNT_EN
    ,
    .CNT_W          (CW)
`endif
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_det(raw_det),
    .country(country),
    .sensor (sensor)
`ifdef VEHICLE_COUNT_EN
    ,
    .vehicle_count(vehicle_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_s1 = 0; m_s2 = 0;
    m_pending = 0; m_granted = 0; m_drained = 0;
    m_high = 0; m_low = 0; m_count = 0;
  endtask

  function automatic bit m_sensor();
    return m_pending && !m_drained;
  endfunction

  task automatic model_edge();
    bit det;
    if (!reset) begin
      m_reset();
      return;
    end
    det = m_s2;
    if (!m_pending) begin
      m_high = det ? m_high + 1 : 0;
      if (m_high == DEB) begin
        m_pending = 1;
        m_high    = 0;
        if (m_count < (1 << 30)) m_count++;
      end
    end else if (!m_granted) begin
      if (country == 2'd2) begin
        m_granted = 1;
        m_low     = 0;
      end
    end else if (country != 2'd2) begin
      m_pending = 0; m_granted = 0; m_drained = 0;
    end else if (!m_drained) begin
      m_low = det ? 0 : m_low + 1;
      if (m_low == GAP) m_drained = 1;
    end
    m_s2 = m_s1;
    m_s1 = raw_det;
  endtask

  function automatic int exp_count();
`ifdef VEHICLE_COUNT_EN
    return (m_count > (1 << CW) - 1) ? (1 << CW) - 1 : m_count;
`else
    return m_count;
`endif
  endfunction

  task automatic cycle(input logic r, input logic [1:0] c);
    raw_det = r;
    country = c;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sensor", 32'(sensor), 32'(m_sensor()));
`ifdef VEHICLE_COUNT_EN
    check_eq("count", 32'(vehicle_count), 32'(exp_count()));
`endif
  endtask

  // Asserts reset between clock edges and checks the output clears at once.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    m_reset();
    check_eq("async_rst", 32'(sensor), 32'd0);
`ifdef VEHICLE_COUNT_EN
    check_eq("async_rst_cnt", 32'(vehicle_count), 32'd0);
`endif
    #1 reset = 1'b1;
  endtask

  initial begin
    bit         pat [7] = '{1, 1, 0, 1, 1, 1, 1};
    int         seg = 0;
    logic       r = 1'b0;
    logic [1:0] c = 2'd0;
    int         sel;

    m_reset();

    // Reset held with a toggling detector
    for (int i = 0; i < 6; i++) begin
      cycle(logic'($urandom_range(0, 1)), 2'd0);
      check_eq("rst_hold", 32'(sensor), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0);
      check_eq("post_rst", 32'(sensor), 32'd0);
    end

    // Clean arrival: sensor after the sixth edge
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 2'd0);
      check_eq("rise", 32'(sensor), 32'(i >= 6));
    end
`ifdef VEHICLE_COUNT_EN
    check_eq("count_one", 32'(vehicle_count), 32'd1);
`endif

    // Bounce pattern restarts qualification
    pulse_reset();
    for (int i = 1; i <= 10; i++) begin
      cycle(i <= 7 ? logic'(pat[i-1]) : 1'b1, 2'd0);
      check_eq("bounce", 32'(sensor), 32'(i >= 9));
    end
    pulse_reset();
    cycle(1'b1, 2'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 2'd0);
      check_eq("pulse", 32'(sensor), 32'd0);
    end

    // Serve, extend, gap drop, drain ignores detector
    pulse_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd0);
      check_eq("req_hold", 32'(sensor), 32'd1);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(logic'(i % 3 == 0), 2'd2);
      check_eq("extend", 32'(sensor), 32'd1);
    end
    for (int j = 0; j < 6; j++) begin
      cycle(1'b0, 2'd2);
      check_eq("gap_drop", 32'(sensor), 32'(j < 2));
    end
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, 2'd2);
      check_eq("drain", 32'(sensor), 32'd0);
    end
    cycle(1'b1, 2'd0);
    check_eq("drain_exit", 32'(sensor), 32'd0);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, 2'd0);
      check_eq("requal", 32'(sensor), 32'(j == 3));
    end

    // Green ends early while the vehicle is still present
    pulse_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd2);
      check_eq("served", 32'(sensor), 32'd1);
    end
    cycle(1'b1, 2'd1);
    check_eq("yellow", 32'(sensor), 32'd0);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, 2'd1);
      check_eq("requal2", 32'(sensor), 32'(j == 3));
    end
`ifdef VEHICLE_COUNT_EN
    check_eq("count_two", 32'(vehicle_count), 32'd2);
`endif

    // Asynchronous reset while a request is pending
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0);
    pulse_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 2'd0);
    check_eq("in_request", 32'(sensor), 32'd1);
    pulse_reset();

`ifdef VEHICLE_COUNT_EN
    // Five vehicles saturate a 2-bit counter at 3
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 6; i++) cycle(1'b1, 2'd0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 2'd2);
      cycle(1'b1, 2'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0);
    end
    check_eq("saturate", 32'(vehicle_count), 32'd3);
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) r = ~r;
      if (seg == 0) begin
        sel = int'($urandom_range(0, 7));
        c   = (sel <= 2) ? 2'd0 : (sel <= 5) ? 2'd2 : (sel == 6) ? 2'd1 : 2'd3;
        seg = int'($urandom_range(2, 25));
      end
      seg--;
      if ($urandom_range(0, 399) == 0) pulse_reset();
      cycle(r, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
